// File: rtl/uart_pkg.sv
// Shared state encoding, parity-mode constants and parameter limits for the
// parameterised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int MIN_DATA_BITS = 1;
    localparam int MAX_DATA_BITS = 16;
    localparam int MIN_STOP_BITS = 1;
    localparam int MAX_STOP_BITS = 2;

    // acc is the XOR of every data bit and the parity bit of one frame.
    function automatic logic parity_ok(input logic acc, input int mode);
        if (mode == PARITY_NONE) begin
            return 1'b1;
        end
        return (mode == PARITY_ODD) ? acc : ~acc;
    endfunction

endpackage

// File: rtl/uart_rx_shifter.sv
// Datapath of the receiver: LSB-first shift register, data-bit counter and
// running parity accumulator, all sequenced by the FSM in uart_rx_param.
module uart_rx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 parity_en,
    input  logic                 signal,
    output logic [DATA_BITS-1:0] shift_data,
    output logic                 last_bit,
    output logic                 parity_acc
);

    // Wide enough to hold DATA_BITS itself, so DATA_BITS=1 still works.
    localparam int CNT_W = $clog2(DATA_BITS) + 1;

    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 parity_reg;
    logic                 parity_next;

    // New bits enter at the MSB and walk down, so the first bit ends at bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_msb
                assign shift_next[gi] = shift_en ? signal : shift_reg[gi];
            end else begin : g_lower
                assign shift_next[gi] = shift_en ? shift_reg[gi+1] : shift_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        parity_next  = parity_reg;
        if (clear) begin
            bit_cnt_next = '0;
            parity_next  = 1'b0;
        end else begin
            if (shift_en) begin
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                parity_next  = parity_reg ^ signal;
            end
            if (parity_en) begin
                parity_next = parity_reg ^ signal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            parity_reg  <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            parity_reg  <= parity_next;
        end
    end

    assign shift_data = shift_reg;
    assign last_bit   = (bit_cnt_reg == CNT_W'(DATA_BITS - 1));
    assign parity_acc = parity_reg;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver, one line bit per clock: frame FSM plus
// registered data/status outputs; datapath lives in uart_rx_shifter.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PARITY_EVEN,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 valid,
    output logic                 parity_error,
    output logic                 framing_error
);

    generate
        if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
            $error("uart_rx_param: DATA_BITS must be 1..16");
        end
        if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
            PARITY_MODE != PARITY_ODD) begin : g_bad_parity_mode
            $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop_bits
            $error("uart_rx_param: STOP_BITS must be 1..2");
        end
    endgenerate

    rx_state_t            state_reg;
    rx_state_t            state_next;
    logic                 stop_cnt_reg;
    logic                 stop_cnt_next;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 valid_reg;
    logic                 valid_next;
    logic                 parity_error_reg;
    logic                 parity_error_next;
    logic                 framing_error_reg;
    logic                 framing_error_next;

    logic                 sh_clear;
    logic                 sh_shift;
    logic                 sh_parity;
    logic [DATA_BITS-1:0] sh_data;
    logic                 sh_last_bit;
    logic                 sh_parity_acc;
    logic                 parity_good;

    uart_rx_shifter #(
        .DATA_BITS (DATA_BITS)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .clear      (sh_clear),
        .shift_en   (sh_shift),
        .parity_en  (sh_parity),
        .signal     (signal),
        .shift_data (sh_data),
        .last_bit   (sh_last_bit),
        .parity_acc (sh_parity_acc)
    );

    assign parity_good = parity_ok(sh_parity_acc, PARITY_MODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= WAIT_HIGH;
            stop_cnt_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            stop_cnt_reg <= stop_cnt_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        stop_cnt_next      = stop_cnt_reg;
        valid_next         = 1'b0;
        parity_error_next  = 1'b0;
        framing_error_next = 1'b0;
        sh_clear           = 1'b0;
        sh_shift           = 1'b0;
        sh_parity          = 1'b0;
        case (state_reg)
            WAIT_HIGH: begin
                if (signal) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!signal) begin
                    state_next = DATA;
                    sh_clear   = 1'b1;
                end
            end
            DATA: begin
                sh_shift = 1'b1;
                if (sh_last_bit) begin
                    state_next    = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    stop_cnt_next = 1'b0;
                end
            end
            PARITY: begin
                sh_parity     = 1'b1;
                state_next    = STOP;
                stop_cnt_next = 1'b0;
            end
            STOP: begin
                // A low stop bit wins over any parity verdict.
                if (!signal) begin
                    framing_error_next = 1'b1;
                    state_next         = WAIT_HIGH;
                end else if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                    state_next = IDLE;
                    if (parity_good) begin
                        valid_next = 1'b1;
                    end else begin
                        parity_error_next = 1'b1;
                    end
                end else begin
                    stop_cnt_next = stop_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = WAIT_HIGH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_reg       <= '0;
            valid_reg         <= 1'b0;
            parity_error_reg  <= 1'b0;
            framing_error_reg <= 1'b0;
        end else begin
            valid_reg         <= valid_next;
            parity_error_reg  <= parity_error_next;
            framing_error_reg <= framing_error_next;
            if (valid_next) begin
                rx_data_reg <= sh_data;
            end
        end
    end

    assign rx_data       = rx_data_reg;
    assign valid         = valid_reg;
    assign parity_error  = parity_error_reg;
    assign framing_error = framing_error_reg;

endmodule
